exec_pipe: RTL and testbench
============================

Name: exec_pipe

Overview:
- Parametrised three-stage execute pipeline: operand capture, shift+ALU, writeback/status commit.
- Sits between the register file and writeback/memory. Successor to the fixed 32-bit execute datapath.
- Adds over that datapath: generic width, NZCV flags with shifter carry, a valid/stall/flush pipeline handshake, writeback tag propagation, an external forwarding source, and async reset.

Parameters:
- DATA_W, 32, datapath width (power of two, >=8).
- SHAMT_W, $clog2(DATA_W), shift-amount bits used.
- RADDR_W, 4, register address width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  issue slot holds an instruction
- stall  in  1  freeze every stage; no state changes
- flush  in  1  kill stage-1 and stage-2 contents
- A_data, B_data, shift_data  in  DATA_W  regfile read ports
- PC  in  DATA_W  current PC
- fwd_data  in  DATA_W  external forward (memory stage)
- sel_A_in, sel_B_in, sel_shift_in  in  2  00 regfile, 01 stage-2 result, 10 fwd_data, 11 PC (A) / imme_data (B) / zero (shift)
- sel_shift  in  1  1: amount = shift operand low SHAMT_W bits; 0: shift_imme
- shift_imme  in  SHAMT_W  immediate shift amount
- shift_op  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- sel_A  in  1  1: ALU A operand forced zero
- ALU_op  in  3  000 ADD, 001 SUB(A-B), 010 RSB(B-A), 011 AND, 100 ORR, 101 EOR, 110 MOV(B), 111 MVN(~B)
- set_flags  in  1  instruction updates NZCV
- wb_en_in  in  1  instruction writes a register
- wb_addr_in  in  RADDR_W  destination register
- imme_data  in  DATA_W  immediate
- datapath_out  out  DATA_W  stage-3 result
- out_valid  out  1  stage 3 holds a valid instruction
- wb_en  out  1  out_valid & carried wb_en
- wb_addr  out  RADDR_W  carried destination
- status_out  out  4  committed NZCV {N,Z,C,V}

Behaviour:
- Reset (async, any time, including mid-operation): all valid bits 0, all data/tag registers 0, status_out = 4'b0000. Deassertion is synchronous-safe; the first capture happens on the next edge.
- Stage 1 (edge E0): if in_valid & ~stall, capture A_reg, B_reg, S_reg (mux outputs), control, and tags; v1 <= 1. Otherwise v1 <= 0 when not stalled.
- Stage 2 (E1): shift B_reg by S_reg, apply ALU; capture out1, flags1, tags; v2 <= v1.
- Stage 3 (E2): out2 <= out1, tags forwarded, v3 <= v2. Fixed latency is 3 edges from issue to out_valid.
- status_out is updated at E2 only when v2 & set_flags2; otherwise it holds.
- Forward select 01 reads out1 (the instruction one ahead), combinationally.
- Shifter with amount 0: output = input, carry_sh = current status_out C, for every op.
  - LSL n: carry = bit DATA_W-n.
  - LSR/ASR n: carry = bit n-1.
  - ROR n: carry = result MSB.
- Flags:
  - N = result MSB; Z = result==0.
  - ADD: C = carry out, V = signed overflow.
  - SUB/RSB: C = NOT borrow, V = signed overflow.
  - Logical/MOV/MVN: C = carry_sh, V = current status_out V.
- stall has priority over everything except rst: all registers and status_out hold, and outputs stay constant.
- flush (without stall): v1, v2 <= 0 at the edge. Stage 3 still advances its current content. The flushed instructions never raise out_valid and never update status.
- flush & stall together: stall wins and flush is ignored that cycle. The controller holds flush until stall drops.
- Invalid bubbles still move data registers, but out_valid, wb_en, and status_out are gated by the valid bits.
- Arithmetic is modulo 2^DATA_W; the carry is computed on a DATA_W+1 bit sum.

Decomposition:
- Package exec_pkg: ALU_op and shift_op enums, forwarding-select constants, NZCV bit indices.
- Sub-module barrel_shifter (parametrised by DATA_W), outputs result and carry_sh. The ALU stays inline in exec_pipe.

Test Plan:
- Reset then issue ADD A=5, B=7, set_flags -> after 3 edges datapath_out=12, out_valid=1, status_out=0000.
- SUB 3-5 with set_flags -> out=0xFFFFFFFE, NZCV=1000. Then SUB 5-5 -> 0, NZCV=0110.
- Back-to-back: ADD r1=1+1, next instruction sel_A_in=01 ADD +3 -> second result 5.
- ASR 0x80000000 by imme 4 -> 0xF8000000. LSR 0x1 by 1, MOV, set_flags -> out 0, NZCV C=1, Z=1.
- Issue 3 instructions, assert stall 2 cycles mid-stream -> out_valid sequence stretched by 2, results unchanged, status_out held.
- flush one cycle after 2 issues -> those 2 never appear; assert rst mid-stream -> out_valid=0 and status_out=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/exec_pkg.sv
// exec_pkg
// Shared definitions for the execute pipeline: ALU and shifter opcodes,
// operand-select codes and the bit positions of the NZCV status word.
package exec_pkg;

  // ALU operation codes as driven on ALU_op
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_RSB = 3'b010,
    ALU_AND = 3'b011,
    ALU_ORR = 3'b100,
    ALU_EOR = 3'b101,
    ALU_MOV = 3'b110,
    ALU_MVN = 3'b111
  } alu_op_e;

  // Barrel shifter operation codes as driven on shift_op
  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_op_e;

  // Operand source selects shared by the A, B and shift operand muxes.
  // SEL_ALT means PC for A, the immediate for B and zero for the shift operand.
  localparam logic [1:0] SEL_REGFILE = 2'b00;
  localparam logic [1:0] SEL_STAGE2  = 2'b01;
  localparam logic [1:0] SEL_FWD     = 2'b10;
  localparam logic [1:0] SEL_ALT     = 2'b11;

  // Bit positions inside the {N,Z,C,V} status word
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/barrel_shifter.sv
// barrel_shifter
// Purely combinational shifter used in the ALU stage of exec_pipe.
// Ports:
//   data_i     - operand to be shifted
//   amount_i   - shift distance (0 .. DATA_W-1)
//   op_i       - LSL / LSR / ASR / ROR
//   carry_i    - current status C, passed through when the distance is zero
//   result_o   - shifted operand
//   carry_sh_o - shifter carry-out (last bit shifted out, MSB for ROR)
module barrel_shifter
  import exec_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0]  data_i,
  input  logic [SHAMT_W-1:0] amount_i,
  input  shift_op_e          op_i,
  input  logic               carry_i,
  output logic [DATA_W-1:0]  result_o,
  output logic               carry_sh_o
);

  logic [DATA_W:0]    lslWide;
  logic [DATA_W:0]    lsrWide;
  logic [DATA_W:0]    asrWide;
  logic [SHAMT_W-1:0] negAmount;

  // Each shift runs on an operand widened by one bit so that the last bit
  // shifted out lands in the extra position and becomes the carry. A rotate
  // is built from a right and a left shift; because DATA_W is a power of two
  // the left distance is simply the negated amount modulo DATA_W.
  always_comb begin
    lslWide   = {1'b0, data_i} << amount_i;
    lsrWide   = {data_i, 1'b0} >> amount_i;
    asrWide   = $signed({data_i, 1'b0}) >>> amount_i;
    negAmount = '0 - amount_i;

    result_o   = data_i;
    carry_sh_o = carry_i;
    if (amount_i != '0) begin
      case (op_i)
        SH_LSL: begin
          result_o   = lslWide[DATA_W-1:0];
          carry_sh_o = lslWide[DATA_W];
        end
        SH_LSR: begin
          result_o   = lsrWide[DATA_W:1];
          carry_sh_o = lsrWide[0];
        end
        SH_ASR: begin
          result_o   = asrWide[DATA_W:1];
          carry_sh_o = asrWide[0];
        end
        SH_ROR: begin
          result_o   = (data_i >> amount_i) | (data_i << negAmount);
          carry_sh_o = result_o[DATA_W-1];
        end
        default: begin
          result_o   = data_i;
          carry_sh_o = carry_i;
        end
      endcase
    end
  end

endmodule

// File: rtl/exec_pipe.sv
// exec_pipe
// Three-stage execute pipeline: operand capture, shift + ALU, then
// writeback/status commit. Instructions leave exactly three edges after
// issue unless stalled.
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   in_valid, stall, flush       - issue valid, global freeze, kill stages 1-2
//   A_data, B_data, shift_data   - register file read data
//   PC, fwd_data, imme_data      - alternate operand sources
//   sel_A_in, sel_B_in,
//   sel_shift_in                 - operand source selects (see exec_pkg)
//   sel_shift, shift_imme        - shift distance from operand or immediate
//   shift_op, sel_A, ALU_op      - shifter op, zero the A operand, ALU op
//   set_flags, wb_en_in,
//   wb_addr_in                   - per-instruction control carried down the pipe
//   datapath_out, out_valid,
//   wb_en, wb_addr               - stage-3 result and writeback request
//   status_out                   - committed NZCV
module exec_pipe
  import exec_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = $clog2(DATA_W),
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               stall,
  input  logic               flush,
  input  logic [DATA_W-1:0]  A_data,
  input  logic [DATA_W-1:0]  B_data,
  input  logic [DATA_W-1:0]  shift_data,
  input  logic [DATA_W-1:0]  PC,
  input  logic [DATA_W-1:0]  fwd_data,
  input  logic [1:0]         sel_A_in,
  input  logic [1:0]         sel_B_in,
  input  logic [1:0]         sel_shift_in,
  input  logic               sel_shift,
  input  logic [SHAMT_W-1:0] shift_imme,
  input  logic [1:0]         shift_op,
  input  logic               sel_A,
  input  logic [2:0]         ALU_op,
  input  logic               set_flags,
  input  logic               wb_en_in,
  input  logic [RADDR_W-1:0] wb_addr_in,
  input  logic [DATA_W-1:0]  imme_data,
  output logic [DATA_W-1:0]  datapath_out,
  output logic               out_valid,
  output logic               wb_en,
  output logic [RADDR_W-1:0] wb_addr,
  output logic [3:0]         status_out
);

  // stage 1: captured operands and control
  logic [DATA_W-1:0]  a_q, b_q, s_q;
  logic [DATA_W-1:0]  a_d, b_d, s_d;
  logic               selShift_q, selA_q, setFlags1_q, wbEn1_q, v1_q;
  logic [SHAMT_W-1:0] shiftImme_q;
  shift_op_e          shiftOp_q;
  alu_op_e            aluOp_q;
  logic [RADDR_W-1:0] wbAddr1_q;

  // stage 2: ALU result and candidate flags
  logic [DATA_W-1:0]  out1_q, out1_d;
  logic [3:0]         flags1_q, flags1_d;
  logic               setFlags2_q, wbEn2_q, v2_q;
  logic [RADDR_W-1:0] wbAddr2_q;

  // stage 3: committed result and status
  logic [DATA_W-1:0]  out2_q;
  logic               wbEn3_q, v3_q;
  logic [RADDR_W-1:0] wbAddr3_q;
  logic [3:0]         status_q;

  logic [SHAMT_W-1:0] shAmount;
  logic [DATA_W-1:0]  shRes;
  logic               shCarry;
  logic [DATA_W-1:0]  opA;
  logic [DATA_W:0]    sumAdd, sumSub, sumRsb;
  logic               aluC, aluV;
  logic               unused_sHigh;

  // Only the low SHAMT_W bits of the shift operand form a distance
  assign unused_sHigh = ^s_q[DATA_W-1:SHAMT_W];

  // Operand muxes. Select 01 takes the ALU output of the instruction now in
  // the ALU stage, so a dependent instruction issued on the very next cycle
  // sees its producer's result without a bubble.
  always_comb begin
    case (sel_A_in)
      SEL_REGFILE: a_d = A_data;
      SEL_STAGE2:  a_d = out1_d;
      SEL_FWD:     a_d = fwd_data;
      default:     a_d = PC;
    endcase
    case (sel_B_in)
      SEL_REGFILE: b_d = B_data;
      SEL_STAGE2:  b_d = out1_d;
      SEL_FWD:     b_d = fwd_data;
      default:     b_d = imme_data;
    endcase
    case (sel_shift_in)
      SEL_REGFILE: s_d = shift_data;
      SEL_STAGE2:  s_d = out1_d;
      SEL_FWD:     s_d = fwd_data;
      default:     s_d = '0;
    endcase
  end

  assign shAmount = selShift_q ? s_q[SHAMT_W-1:0] : shiftImme_q;

  barrel_shifter #(
    .DATA_W (DATA_W),
    .SHAMT_W(SHAMT_W)
  ) u_shifter (
    .data_i    (b_q),
    .amount_i  (shAmount),
    .op_i      (shiftOp_q),
    .carry_i   (status_q[FLAG_C]),
    .result_o  (shRes),
    .carry_sh_o(shCarry)
  );

  // ALU. Subtractions are done as A + ~B + 1 on a DATA_W+1 bit sum so that
  // the top bit is directly the NOT-borrow carry. Logical ops pass the
  // shifter carry and keep the committed V.
  always_comb begin
    opA    = sel_A ? '0 : '0;
    opA    = selA_q ? '0 : a_q;
    sumAdd = {1'b0, opA} + {1'b0, shRes};
    sumSub = {1'b0, opA} + {1'b0, ~shRes} + (DATA_W+1)'(1);
    sumRsb = {1'b0, shRes} + {1'b0, ~opA} + (DATA_W+1)'(1);
    out1_d = shRes;
    aluC   = shCarry;
    aluV   = status_q[FLAG_V];
    case (aluOp_q)
      ALU_ADD: begin
        out1_d = sumAdd[DATA_W-1:0];
        aluC   = sumAdd[DATA_W];
        aluV   = (opA[DATA_W-1] == shRes[DATA_W-1]) &&
                 (out1_d[DATA_W-1] != opA[DATA_W-1]);
      end
      ALU_SUB: begin
        out1_d = sumSub[DATA_W-1:0];
        aluC   = sumSub[DATA_W];
        aluV   = (opA[DATA_W-1] != shRes[DATA_W-1]) &&
                 (out1_d[DATA_W-1] != opA[DATA_W-1]);
      end
      ALU_RSB: begin
        out1_d = sumRsb[DATA_W-1:0];
        aluC   = sumRsb[DATA_W];
        aluV   = (shRes[DATA_W-1] != opA[DATA_W-1]) &&
                 (out1_d[DATA_W-1] != shRes[DATA_W-1]);
      end
      ALU_AND: out1_d = opA & shRes;
      ALU_ORR: out1_d = opA | shRes;
      ALU_EOR: out1_d = opA ^ shRes;
      ALU_MOV: out1_d = shRes;
      ALU_MVN: out1_d = ~shRes;
      default: out1_d = shRes;
    endcase
    flags1_d         = '0;
    flags1_d[FLAG_N] = out1_d[DATA_W-1];
    flags1_d[FLAG_Z] = (out1_d == '0);
    flags1_d[FLAG_C] = aluC;
    flags1_d[FLAG_V] = aluV;
  end

  // Stage 1 capture. Data registers follow the muxes on every unstalled
  // edge; only the valid bit says whether an instruction is really there.
  // A flush also drops the instruction being issued on that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      selShift_q  <= 1'b0;
      shiftImme_q <= '0;
      shiftOp_q   <= SH_LSL;
      selA_q      <= 1'b0;
      aluOp_q     <= ALU_ADD;
      setFlags1_q <= 1'b0;
      wbEn1_q     <= 1'b0;
      wbAddr1_q   <= '0;
      v1_q        <= 1'b0;
    end else if (!stall) begin
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      selShift_q  <= sel_shift;
      shiftImme_q <= shift_imme;
      shiftOp_q   <= shift_op_e'(shift_op);
      selA_q      <= sel_A;
      aluOp_q     <= alu_op_e'(ALU_op);
      setFlags1_q <= set_flags;
      wbEn1_q     <= wb_en_in;
      wbAddr1_q   <= wb_addr_in;
      v1_q        <= in_valid & ~flush;
    end
  end

  // Stage 2 register: ALU result, candidate flags and carried tags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out1_q      <= '0;
      flags1_q    <= '0;
      setFlags2_q <= 1'b0;
      wbEn2_q     <= 1'b0;
      wbAddr2_q   <= '0;
      v2_q        <= 1'b0;
    end else if (!stall) begin
      out1_q      <= out1_d;
      flags1_q    <= flags1_d;
      setFlags2_q <= setFlags1_q;
      wbEn2_q     <= wbEn1_q;
      wbAddr2_q   <= wbAddr1_q;
      v2_q        <= v1_q & ~flush;
    end
  end

  // Stage 3 and status commit. The instruction leaving stage 2 on a flush
  // edge is one of the killed ones, so it neither becomes valid here nor
  // touches the status word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out2_q    <= '0;
      wbEn3_q   <= 1'b0;
      wbAddr3_q <= '0;
      v3_q      <= 1'b0;
      status_q  <= '0;
    end else if (!stall) begin
      out2_q    <= out1_q;
      wbEn3_q   <= wbEn2_q;
      wbAddr3_q <= wbAddr2_q;
      v3_q      <= v2_q & ~flush;
      if (v2_q && setFlags2_q && !flush) begin
        status_q <= flags1_q;
      end
    end
  end

  assign datapath_out = out2_q;
  assign out_valid    = v3_q;
  assign wb_en        = v3_q & wbEn3_q;
  assign wb_addr      = wbAddr3_q;
  assign status_out   = status_q;

endmodule

// File: tb/tb_exec_pipe.sv
// tb_exec_pipe
// Directed and randomized checks of exec_pipe against a transaction-level
// reference model (per-instruction records moving through three slots, with
// the shift done bit by bit and the flags derived from wide arithmetic).
module tb_exec_pipe;
  import exec_pkg::*;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;
  localparam int RADDR_W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, stall, flush;
  logic [DATA_W-1:0]  A_data, B_data, shift_data, PC, fwd_data, imme_data;
  logic [1:0]         sel_A_in, sel_B_in, sel_shift_in;
  logic               sel_shift;
  logic [SHAMT_W-1:0] shift_imme;
  logic [1:0]         shift_op;
  logic               sel_A;
  logic [2:0]         ALU_op;
  logic               set_flags, wb_en_in;
  logic [RADDR_W-1:0] wb_addr_in;
  logic [DATA_W-1:0]  datapath_out;
  logic               out_valid, wb_en;
  logic [RADDR_W-1:0] wb_addr;
  logic [3:0]         status_out;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] obsQ[$];

  always #5 clk = ~clk;

  exec_pipe #(
    .DATA_W (DATA_W),
    .SHAMT_W(SHAMT_W),
    .RADDR_W(RADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .stall       (stall),
    .flush       (flush),
    .A_data      (A_data),
    .B_data      (B_data),
    .shift_data  (shift_data),
    .PC          (PC),
    .fwd_data    (fwd_data),
    .sel_A_in    (sel_A_in),
    .sel_B_in    (sel_B_in),
    .sel_shift_in(sel_shift_in),
    .sel_shift   (sel_shift),
    .shift_imme  (shift_imme),
    .shift_op    (shift_op),
    .sel_A       (sel_A),
    .ALU_op      (ALU_op),
    .set_flags   (set_flags),
    .wb_en_in    (wb_en_in),
    .wb_addr_in  (wb_addr_in),
    .imme_data   (imme_data),
    .datapath_out(datapath_out),
    .out_valid   (out_valid),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .status_out  (status_out)
  );

  // Reference model records
  typedef struct {
    logic        valid;
    logic [31:0] a, b, s;
    logic        selShift;
    logic [4:0]  shImm;
    logic [1:0]  shOp;
    logic        selA;
    logic [2:0]  op;
    logic        sf, we;
    logic [3:0]  wa;
  } instr_t;

  typedef struct {
    logic        valid;
    logic [31:0] res;
    logic [3:0]  flags;
    logic        sf, we;
    logic [3:0]  wa;
  } result_t;

  instr_t     m1;
  result_t    m2, m3;
  logic [3:0] mStatus;

  // Executes one instruction given the status word visible to it
  function automatic result_t execute(instr_t ins, logic [3:0] st);
    result_t           r;
    logic [31:0]       x, aa, y;
    logic              c, v;
    int                amt;
    longint unsigned   ua, ub;
    longint            sa, sb, sr;
    amt = ins.selShift ? int'(ins.s[4:0]) : int'(ins.shImm);
    x   = ins.b;
    c   = st[1];
    for (int k = 0; k < amt; k++) begin
      case (ins.shOp)
        2'd0:    begin c = x[31]; x = {x[30:0], 1'b0};  end
        2'd1:    begin c = x[0];  x = {1'b0, x[31:1]};  end
        2'd2:    begin c = x[0];  x = {x[31], x[31:1]}; end
        default: begin c = x[0];  x = {x[0], x[31:1]};  end
      endcase
    end
    aa = ins.selA ? 32'h0 : ins.a;
    ua = aa;
    ub = x;
    sa = $signed(aa);
    sb = $signed(x);
    v  = st[0];
    sr = 0;
    case (ins.op)
      ALU_ADD: begin
        y = aa + x; c = ((ua + ub) >> 32) != 0;
        sr = sa + sb; v = (sr != longint'($signed(y)));
      end
      ALU_SUB: begin
        y = aa - x; c = (ua >= ub);
        sr = sa - sb; v = (sr != longint'($signed(y)));
      end
      ALU_RSB: begin
        y = x - aa; c = (ub >= ua);
        sr = sb - sa; v = (sr != longint'($signed(y)));
      end
      ALU_AND: y = aa & x;
      ALU_ORR: y = aa | x;
      ALU_EOR: y = aa ^ x;
      ALU_MOV: y = x;
      default: y = ~x;
    endcase
    r.valid = ins.valid;
    r.res   = y;
    r.flags = {y[31], (y == 32'h0), c, v};
    r.sf    = ins.sf;
    r.we    = ins.we;
    r.wa    = ins.wa;
    return r;
  endfunction

  task automatic modelReset();
    m1      = '{valid: 1'b0, a: '0, b: '0, s: '0, selShift: 1'b0, shImm: '0,
                shOp: '0, selA: 1'b0, op: '0, sf: 1'b0, we: 1'b0, wa: '0};
    m2      = '{valid: 1'b0, res: '0, flags: '0, sf: 1'b0, we: 1'b0, wa: '0};
    m3      = m2;
    mStatus = 4'b0000;
  endtask

  function automatic logic [31:0] pick(logic [1:0] sel, logic [31:0] rf,
                                       logic [31:0] ahead, logic [31:0] alt);
    case (sel)
      2'b00:   return rf;
      2'b01:   return ahead;
      2'b10:   return fwd_data;
      default: return alt;
    endcase
  endfunction

  // Advances the model by one edge using the inputs seen at that edge
  task automatic modelStep();
    instr_t     n1;
    result_t    n2, n3, ahead;
    logic [3:0] nSt;
    if (rst) begin
      modelReset();
      return;
    end
    if (stall) return;
    ahead = execute(m1, mStatus);
    nSt   = mStatus;
    if (m2.valid && m2.sf && !flush) nSt = m2.flags;
    n3       = m2;
    n3.valid = m2.valid && !flush;
    n2       = ahead;
    n2.valid = m1.valid && !flush;
    n1.a        = pick(sel_A_in, A_data, ahead.res, PC);
    n1.b        = pick(sel_B_in, B_data, ahead.res, imme_data);
    n1.s        = pick(sel_shift_in, shift_data, ahead.res, 32'h0);
    n1.selShift = sel_shift;
    n1.shImm    = shift_imme;
    n1.shOp     = shift_op;
    n1.selA     = sel_A;
    n1.op       = ALU_op;
    n1.sf       = set_flags;
    n1.we       = wb_en_in;
    n1.wa       = wb_addr_in;
    n1.valid    = in_valid && !flush;
    m1 = n1;
    m2 = n2;
    m3 = n3;
    mStatus = nSt;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string where);
    cmp({where, "/out_valid"}, 32'(out_valid), 32'(m3.valid));
    cmp({where, "/wb_en"}, 32'(wb_en), 32'(m3.valid & m3.we));
    cmp({where, "/status"}, 32'(status_out), 32'(mStatus));
    if (m3.valid) begin
      cmp({where, "/data"}, datapath_out, m3.res);
      cmp({where, "/wb_addr"}, 32'(wb_addr), 32'(m3.wa));
    end
  endtask

  task automatic tick(input string where);
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput(where);
    if (out_valid === 1'b1) obsQ.push_back(datapath_out);
  endtask

  task automatic applyStimulus(input logic [1:0] aSel, input logic [1:0] bSel,
                               input logic [1:0] sSel, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] sh,
                               input logic selSh, input logic [4:0] shImm,
                               input logic [1:0] shOp, input logic selA,
                               input logic [2:0] op, input logic sf,
                               input logic [3:0] wa);
    in_valid     = 1'b1;
    sel_A_in     = aSel;
    sel_B_in     = bSel;
    sel_shift_in = sSel;
    A_data       = a;
    B_data       = b;
    shift_data   = sh;
    sel_shift    = selSh;
    shift_imme   = shImm;
    shift_op     = shOp;
    sel_A        = selA;
    ALU_op       = op;
    set_flags    = sf;
    wb_en_in     = 1'b1;
    wb_addr_in   = wa;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    set_flags = 1'b0;
    wb_en_in  = 1'b0;
  endtask

  function automatic logic [31:0] randData();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    PC = 32'h0000_1000;
    fwd_data = 32'hCAFE_0000;
    imme_data = 32'h0000_0010;
    applyStimulus(2'b00, 2'b00, 2'b00, 0, 0, 0, 1'b0, 5'd0, SH_LSL, 1'b0, ALU_ADD, 1'b0, 4'd0);
    idle();
    modelReset();
    @(negedge clk);
    @(negedge clk);
    cmp("reset/out_valid", 32'(out_valid), 32'h0);
    cmp("reset/wb_en", 32'(wb_en), 32'h0);
    cmp("reset/wb_addr", 32'(wb_addr), 32'h0);
    cmp("reset/data", datapath_out, 32'h0);
    cmp("reset/status", 32'(status_out), 32'h0);
    rst = 1'b0;

    // ADD 5 + 7 with flags: result after three edges
    applyStimulus(2'b00, 2'b00, 2'b00, 5, 7, 0, 1'b0, 5'd0, SH_LSL, 1'b0, ALU_ADD, 1'b1, 4'd3);
    tick("add");
    idle();
    tick("add");
    tick("add");
    cmp("add/data", datapath_out, 32'd12);
    cmp("add/out_valid", 32'(out_valid), 32'h1);
    cmp("add/status", 32'(status_out), 32'h0);

    // SUB 3-5 then SUB 5-5
    applyStimulus(2'b00, 2'b00, 2'b00, 3, 5, 0, 1'b0, 5'd0, SH_LSL, 1'b0, ALU_SUB, 1'b1, 4'd1);
    tick("sub");
    applyStimulus(2'b00, 2'b00, 2'b00, 5, 5, 0, 1'b0, 5'd0, SH_LSL, 1'b0, ALU_SUB, 1'b1, 4'd2);
    tick("sub");
    idle();
    tick("sub");
    cmp("sub_neg/data", datapath_out, 32'hFFFF_FFFE);
    cmp("sub_neg/status", 32'(status_out), 32'b1000);
    tick("sub");
    cmp("sub_zero/data", datapath_out, 32'h0);
    cmp("sub_zero/status", 32'(status_out), 32'b0110);

    // Back-to-back dependency through the stage-2 forward
    applyStimulus(2'b00, 2'b00, 2'b00, 1, 1, 0, 1'b0, 5'd0, SH_LSL, 1'b0, ALU_ADD, 1'b0, 4'd1);
    tick("fwd");
    applyStimulus(2'b01, 2'b00, 2'b00, 0, 3, 0, 1'b0, 5'd0, SH_LSL, 1'b0, ALU_ADD, 1'b0, 4'd2);
    tick("fwd");
    idle();
    tick("fwd");
    cmp("fwd_first/data", datapath_out, 32'd2);
    tick("fwd");
    cmp("fwd_second/data", datapath_out, 32'd5);

    // ASR by immediate, then LSR by one with MOV and flags
    applyStimulus(2'b00, 2'b00, 2'b00, 0, 32'h8000_0000, 0, 1'b0, 5'd4, SH_ASR, 1'b0, ALU_MOV, 1'b0, 4'd4);
    tick("shift");
    applyStimulus(2'b00, 2'b00, 2'b00, 0, 32'h1, 0, 1'b0, 5'd1, SH_LSR, 1'b0, ALU_MOV, 1'b1, 4'd5);
    tick("shift");
    idle();
    tick("shift");
    cmp("asr/data", datapath_out, 32'hF800_0000);
    tick("shift");
    cmp("lsr/data", datapath_out, 32'h0);
    cmp("lsr/status", 32'(status_out), 32'b0110);

    // Stall for two cycles in the middle of three issues
    obsQ.delete();
    applyStimulus(2'b00, 2'b00, 2'b00, 10, 1, 0, 1'b0, 5'd0, SH_LSL, 1'b0, ALU_ADD, 1'b0, 4'd6);
    tick("stall");
    applyStimulus(2'b00, 2'b00, 2'b00, 20, 2, 0, 1'b0, 5'd0, SH_LSL, 1'b0, ALU_ADD, 1'b0, 4'd7);
    tick("stall");
    idle();
    stall = 1'b1;
    tick("stall");
    tick("stall");
    stall = 1'b0;
    applyStimulus(2'b00, 2'b00, 2'b00, 30, 3, 0, 1'b0, 5'd0, SH_LSL, 1'b0, ALU_ADD, 1'b0, 4'd8);
    tick("stall");
    idle();
    for (int i = 0; i < 4; i++) tick("stall");
    cmp("stall/count", 32'(obsQ.size()), 32'd3);
    if (obsQ.size() == 3) begin
      cmp("stall/r0", obsQ[0], 32'd11);
      cmp("stall/r1", obsQ[1], 32'd22);
      cmp("stall/r2", obsQ[2], 32'd33);
    end
    cmp("stall/status", 32'(status_out), 32'b0110);

    // Flush right after two issues: neither may appear or set flags
    obsQ.delete();
    applyStimulus(2'b00, 2'b00, 2'b00, 3, 5, 0, 1'b0, 5'd0, SH_LSL, 1'b0, ALU_SUB, 1'b1, 4'd9);
    tick("flush");
    applyStimulus(2'b00, 2'b00, 2'b00, 32'h7FFF_FFFF, 1, 0, 1'b0, 5'd0, SH_LSL, 1'b0, ALU_ADD, 1'b1, 4'd10);
    tick("flush");
    idle();
    flush = 1'b1;
    tick("flush");
    flush = 1'b0;
    for (int i = 0; i < 3; i++) tick("flush");
    cmp("flush/count", 32'(obsQ.size()), 32'd0);
    cmp("flush/status", 32'(status_out), 32'b0110);

    // Randomized traffic with occasional stall and flush
    for (int i = 0; i < 400; i++) begin
      stall        = ($urandom_range(0, 9) == 0);
      flush        = ($urandom_range(0, 19) == 0);
      in_valid     = ($urandom_range(0, 3) != 0);
      sel_A_in     = 2'($urandom_range(0, 3));
      sel_B_in     = 2'($urandom_range(0, 3));
      sel_shift_in = 2'($urandom_range(0, 3));
      if (!m1.valid && sel_A_in == 2'b01) sel_A_in = 2'b00;
      if (!m1.valid && sel_B_in == 2'b01) sel_B_in = 2'b00;
      if (!m1.valid && sel_shift_in == 2'b01) sel_shift_in = 2'b00;
      A_data       = randData();
      B_data       = randData();
      shift_data   = $urandom;
      fwd_data     = randData();
      imme_data    = randData();
      PC           = $urandom;
      sel_shift    = 1'($urandom_range(0, 1));
      shift_imme   = 5'($urandom_range(0, 31));
      shift_op     = 2'($urandom_range(0, 3));
      sel_A        = ($urandom_range(0, 7) == 0);
      ALU_op       = 3'($urandom_range(0, 7));
      set_flags    = 1'($urandom_range(0, 1));
      wb_en_in     = 1'($urandom_range(0, 1));
      wb_addr_in   = 4'($urandom_range(0, 15));
      tick("rand");
    end
    stall = 1'b0;
    flush = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) tick("drain");

    // Asynchronous reset in the middle of traffic
    applyStimulus(2'b00, 2'b00, 2'b00, 3, 5, 0, 1'b0, 5'd0, SH_LSL, 1'b0, ALU_SUB, 1'b1, 4'd11);
    tick("rst");
    applyStimulus(2'b00, 2'b00, 2'b00, 1, 1, 0, 1'b0, 5'd0, SH_LSL, 1'b0, ALU_ADD, 1'b1, 4'd12);
    tick("rst");
    idle();
    tick("rst");
    cmp("pre_rst/out_valid", 32'(out_valid), 32'h1);
    cmp("pre_rst/status", 32'(status_out), 32'b1000);
    #2;
    rst = 1'b1;
    #1;
    cmp("async_rst/out_valid", 32'(out_valid), 32'h0);
    cmp("async_rst/wb_en", 32'(wb_en), 32'h0);
    cmp("async_rst/status", 32'(status_out), 32'h0);
    cmp("async_rst/data", datapath_out, 32'h0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    obsQ.delete();
    for (int i = 0; i < 3; i++) tick("post_rst");
    cmp("post_rst/count", 32'(obsQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
